// File: rtl/decode_issue_stage.sv
// LC-3b decode/issue: regfile read, B-operand select, pending-write scoreboard; WB_BYPASS_EN forwards write-back data.
// Latency: 1 cycle from accept to out_valid through the ID/EX register.
// Backpressure: in_ready drops on RAW/WAW hazard, flush, or a held ID/EX entry while out_ready is low.
module decode_issue_stage #(
    parameter int DATA_W   = 16,
    parameter int SB_CNT_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [2:0]        out_dest,
    output logic              out_wr_en,
    output logic [DATA_W-1:0] out_sr1_data,
    output logic [DATA_W-1:0] out_opb,
    output logic [DATA_W-1:0] out_st_data,
    output logic [10:0]       out_offset11,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [2:0]        wb_reg,
    input  logic [DATA_W-1:0] wb_data
);
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_STB  = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_SHF  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;
    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0]   rf     [8];
    logic [SB_CNT_W-1:0] sb_cnt [8];
    logic [SB_CNT_W-1:0] cnt_nxt[8];

    logic [3:0]        opcode;
    logic [2:0]        dest_f, sr1, sr2, wr_reg;
    logic              wr_en, rd_sr1, rd_sr2, rd_st;
    logic [DATA_W-1:0] sr1_val, sr2_val, st_val, opb;
    logic              sr1_busy, sr2_busy, st_busy, hazard, accept;
    logic [7:0]        inc_vec, wbdec_vec, fldec_vec;

    assign opcode = instruction[15:12];
    assign dest_f = instruction[11:9];
    assign sr1    = instruction[8:6];
    assign sr2    = instruction[2:0];

    always_comb begin
        wr_en  = 1'b0;
        rd_sr1 = 1'b0;
        case (opcode)
            OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_LDB, OP_SHF: begin
                wr_en  = 1'b1;
                rd_sr1 = 1'b1;
            end
            OP_LEA, OP_TRAP:        wr_en  = 1'b1;
            OP_STR, OP_STB, OP_JMP: rd_sr1 = 1'b1;
            OP_JSR: begin
                wr_en  = 1'b1;
                rd_sr1 = !instruction[11];
            end
            default: ;
        endcase
    end

    assign rd_sr2 = (opcode == OP_ADD || opcode == OP_AND) && !instruction[5];
    assign rd_st  = (opcode == OP_STR || opcode == OP_STB);
    assign wr_reg = (opcode == OP_JSR || opcode == OP_TRAP) ? 3'd7 : dest_f;

    // Same-cycle regfile write is not visible here unless forwarding is built in.
    always_comb begin
        sr1_val  = rf[sr1];
        sr2_val  = rf[sr2];
        st_val   = rf[dest_f];
        sr1_busy = (sb_cnt[sr1] != '0);
        sr2_busy = (sb_cnt[sr2] != '0);
        st_busy  = (sb_cnt[dest_f] != '0);
`ifdef WB_BYPASS_EN
        if (wb_valid && wb_reg == sr1) begin
            sr1_val  = wb_data;
            sr1_busy = (sb_cnt[sr1] > SB_CNT_W'(1));
        end
        if (wb_valid && wb_reg == sr2) begin
            sr2_val  = wb_data;
            sr2_busy = (sb_cnt[sr2] > SB_CNT_W'(1));
        end
        if (wb_valid && wb_reg == dest_f) begin
            st_val  = wb_data;
            st_busy = (sb_cnt[dest_f] > SB_CNT_W'(1));
        end
`endif
    end

    always_comb begin
        opb = sr2_val;
        case (opcode)
            OP_ADD, OP_AND: if (instruction[5]) opb = {{(DATA_W-5){instruction[4]}}, instruction[4:0]};
            OP_SHF:         opb = {{(DATA_W-4){1'b0}}, instruction[3:0]};
            OP_LDR, OP_STR: opb = {{(DATA_W-7){instruction[5]}}, instruction[5:0], 1'b0};
            OP_LDB, OP_STB: opb = {{(DATA_W-6){instruction[5]}}, instruction[5:0]};
            default: ;
        endcase
    end

    assign hazard   = (rd_sr1 && sr1_busy) || (rd_sr2 && sr2_busy) || (rd_st && st_busy)
                    || (wr_en && sb_cnt[wr_reg] == CNT_MAX);
    assign in_ready = reset_n && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign inc_vec   = (accept && wr_en) ? (8'b1 << wr_reg) : 8'b0;
    assign wbdec_vec = wb_valid ? (8'b1 << wb_reg) : 8'b0;
    assign fldec_vec = (flush && out_valid && out_wr_en) ? (8'b1 << out_dest) : 8'b0;

    // Accept never coincides with flush, so an increment meets at most the write-back decrement.
    always_comb begin
        for (int r = 0; r < 8; r++) begin
            cnt_nxt[r] = sb_cnt[r];
            if (inc_vec[r] && !wbdec_vec[r]) begin
                cnt_nxt[r] = sb_cnt[r] + SB_CNT_W'(1);
            end else if (!inc_vec[r]) begin
                if (wbdec_vec[r] && fldec_vec[r])
                    cnt_nxt[r] = (sb_cnt[r] > SB_CNT_W'(1)) ? sb_cnt[r] - SB_CNT_W'(2) : '0;
                else if (wbdec_vec[r] || fldec_vec[r])
                    cnt_nxt[r] = (sb_cnt[r] != '0) ? sb_cnt[r] - SB_CNT_W'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < 8; r++) begin
                rf[r]     <= '0;
                sb_cnt[r] <= '0;
            end
            out_valid    <= 1'b0;
            out_opcode   <= '0;
            out_dest     <= '0;
            out_wr_en    <= 1'b0;
            out_sr1_data <= '0;
            out_opb      <= '0;
            out_st_data  <= '0;
            out_offset11 <= '0;
        end else begin
            for (int r = 0; r < 8; r++) sb_cnt[r] <= cnt_nxt[r];
            if (wb_valid) rf[wb_reg] <= wb_data;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid    <= 1'b1;
                out_opcode   <= opcode;
                out_dest     <= wr_reg;
                out_wr_en    <= wr_en;
                out_sr1_data <= sr1_val;
                out_opb      <= opb;
                out_st_data  <= st_val;
                out_offset11 <= instruction[10:0];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: operand select, scoreboard stalls, backpressure, flush, saturation.
module tb_decode_issue_stage;
    localparam int DATA_W   = 16;
    localparam int SB_CNT_W = 2;

    logic              clk;
    logic              reset_n, in_valid, in_ready, out_valid, out_ready, out_wr_en;
    logic              flush, wb_valid;
    logic [15:0]       instruction;
    logic [3:0]        out_opcode;
    logic [2:0]        out_dest, wb_reg;
    logic [DATA_W-1:0] out_sr1_data, out_opb, out_st_data, wb_data;
    logic [10:0]       out_offset11;

    int checks = 0;
    int errors = 0;

    logic [15:0] tbl_ins  [4] = '{16'h6702, 16'hDC9A, 16'h353F, 16'h1A84};
    logic [15:0] tbl_opb  [4] = '{16'h0004, 16'h000A, 16'hFFFF, 16'h0100};
    logic [15:0] tbl_sr1  [4] = '{16'h0100, 16'h0005, 16'h0100, 16'h0005};
    logic [15:0] tbl_st   [4] = '{16'h0000, 16'h0000, 16'h0005, 16'h0000};
    logic [2:0]  tbl_dest [4] = '{3'd3, 3'd6, 3'd2, 3'd5};
    logic        tbl_wr   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    decode_issue_stage #(.DATA_W(DATA_W), .SB_CNT_W(SB_CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_dest(out_dest), .out_wr_en(out_wr_en),
        .out_sr1_data(out_sr1_data), .out_opb(out_opb), .out_st_data(out_st_data),
        .out_offset11(out_offset11), .flush(flush),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [2:0] r, input logic [15:0] d);
        wb_valid = 1'b1;
        wb_reg   = r;
        wb_data  = d;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b1; instruction = 16'h12BD; out_ready = 1'b1;
        flush = 1'b0; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_opb !== 16'h0 || out_sr1_data !== 16'h0 || out_dest !== 3'd0 || out_st_data !== 16'h0)
            begin errors++; $display("FAIL reset_out_data: opb %h sr1 %h dest %0d st %h want all 0", out_opb, out_sr1_data, out_dest, out_st_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_held: got %b want 0", in_ready); end
        for (int r = 0; r < 8; r++) begin
            checks++; if (dut.sb_cnt[r] !== 2'd0) begin errors++; $display("FAIL reset_cnt%0d: got %0d want 0", r, dut.sb_cnt[r]); end
        end
        reset_n = 1'b1; in_valid = 1'b0;
        step();
    endtask

    task automatic test_operand_select;
        wb_write(3'd2, 16'h0005);
        wb_write(3'd4, 16'h0100);
        in_valid = 1'b1; instruction = 16'h12BD;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_imm_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_imm_early_valid: got %b want 0", out_valid); end
        step(); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_imm_valid: got %b want 1", out_valid); end
        checks++; if (out_opb !== 16'hFFFD) begin errors++; $display("FAIL add_imm_opb: got %h want fffd", out_opb); end
        checks++; if (out_sr1_data !== 16'h0005) begin errors++; $display("FAIL add_imm_sr1: got %h want 0005", out_sr1_data); end
        checks++; if (out_dest !== 3'd1 || out_wr_en !== 1'b1 || out_opcode !== 4'h1)
            begin errors++; $display("FAIL add_imm_ctl: dest %0d wr %b op %h want 1 1 1", out_dest, out_wr_en, out_opcode); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; instruction = tbl_ins[i];
            @(negedge clk);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sel%0d_ready: got %b want 1", i, in_ready); end
            step(); in_valid = 1'b0;
            checks++; if (out_opb !== tbl_opb[i]) begin errors++; $display("FAIL sel%0d_opb: got %h want %h", i, out_opb, tbl_opb[i]); end
            checks++; if (out_sr1_data !== tbl_sr1[i]) begin errors++; $display("FAIL sel%0d_sr1: got %h want %h", i, out_sr1_data, tbl_sr1[i]); end
            checks++; if (out_st_data !== tbl_st[i]) begin errors++; $display("FAIL sel%0d_st: got %h want %h", i, out_st_data, tbl_st[i]); end
            checks++; if (out_dest !== tbl_dest[i] || out_wr_en !== tbl_wr[i])
                begin errors++; $display("FAIL sel%0d_ctl: dest %0d wr %b want %0d %b", i, out_dest, out_wr_en, tbl_dest[i], tbl_wr[i]); end
        end
        wb_write(3'd1, 16'h0011);
        wb_write(3'd3, 16'h0000);
        wb_write(3'd5, 16'h0000);
        wb_write(3'd6, 16'h0000);
    endtask

    task automatic test_raw;
        in_valid = 1'b1; instruction = 16'h1261;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_first_ready: got %b want 1", in_ready); end
        step();
        checks++; if (out_sr1_data !== 16'h0011) begin errors++; $display("FAIL raw_first_sr1: got %h want 0011", out_sr1_data); end
        instruction = 16'h1460;
        repeat (3) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall: got %b want 0", in_ready); end
        end
        wb_valid = 1'b1; wb_reg = 3'd1; wb_data = 16'h0042;
        #1;
`ifdef WB_BYPASS_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_bypass_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        wb_valid = 1'b0; in_valid = 1'b0;
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_after_wb_ready: got %b want 1", in_ready); end
        step(); in_valid = 1'b0;
`endif
        checks++; if (out_valid !== 1'b1 || out_dest !== 3'd2) begin errors++; $display("FAIL raw_second_issue: valid %b dest %0d want 1 2", out_valid, out_dest); end
        checks++; if (out_sr1_data !== 16'h0042) begin errors++; $display("FAIL raw_second_sr1: got %h want 0042", out_sr1_data); end
        wb_write(3'd2, 16'h0005);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0; in_valid = 1'b1; instruction = 16'h1684;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b want 1", in_ready); end
        step();
        instruction = 16'h9D3F;
        repeat (3) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
            checks++; if (out_valid !== 1'b1 || out_dest !== 3'd3 || out_opb !== 16'h0100 || out_sr1_data !== 16'h0005)
                begin errors++; $display("FAIL bp_hold: valid %b dest %0d opb %h sr1 %h want 1 3 0100 0005", out_valid, out_dest, out_opb, out_sr1_data); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_opcode !== 4'h9 || out_dest !== 3'd6 || out_sr1_data !== 16'h0100)
            begin errors++; $display("FAIL bp_next: valid %b op %h dest %0d sr1 %h want 1 9 6 0100", out_valid, out_opcode, out_dest, out_sr1_data); end
        wb_write(3'd3, 16'h0000);
        wb_write(3'd6, 16'h0000);
    endtask

    task automatic test_flush;
        out_ready = 1'b0; in_valid = 1'b1; instruction = 16'h1AA1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_issue_ready: got %b want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || dut.sb_cnt[5] !== 2'd1)
            begin errors++; $display("FAIL flush_pre: valid %b cnt5 %0d want 1 1", out_valid, dut.sb_cnt[5]); end
        flush = 1'b1; instruction = 16'hE005;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        checks++; if (dut.sb_cnt[5] !== 2'd0) begin errors++; $display("FAIL flush_cnt5: got %0d want 0", dut.sb_cnt[5]); end
        checks++; if (dut.sb_cnt[0] !== 2'd0) begin errors++; $display("FAIL flush_no_accept_cnt0: got %0d want 0", dut.sb_cnt[0]); end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_saturation;
        in_valid = 1'b1; instruction = 16'h4801;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL jsr%0d_ready: got %b want 1", i, in_ready); end
            step();
            checks++; if (out_dest !== 3'd7 || out_wr_en !== 1'b1 || out_offset11 !== 11'h001)
                begin errors++; $display("FAIL jsr%0d_out: dest %0d wr %b off %h want 7 1 001", i, out_dest, out_wr_en, out_offset11); end
        end
        checks++; if (dut.sb_cnt[7] !== 2'd3) begin errors++; $display("FAIL jsr_cnt_sat: got %0d want 3", dut.sb_cnt[7]); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL jsr_sat_stall: got %b want 0", in_ready); end
        end
        wb_valid = 1'b1; wb_reg = 3'd7; wb_data = 16'h3000;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL jsr_wb_cycle_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (dut.sb_cnt[7] !== 2'd2) begin errors++; $display("FAIL jsr_cnt_after_wb: got %0d want 2", dut.sb_cnt[7]); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL jsr4_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0; wb_valid = 1'b0;
        checks++; if (dut.sb_cnt[7] !== 2'd2 || out_valid !== 1'b1)
            begin errors++; $display("FAIL jsr_inc_dec_same: cnt %0d valid %b want 2 1", dut.sb_cnt[7], out_valid); end
        wb_write(3'd7, 16'h0001);
        wb_write(3'd7, 16'h0002);
        checks++; if (dut.sb_cnt[7] !== 2'd0) begin errors++; $display("FAIL jsr_drain: got %0d want 0", dut.sb_cnt[7]); end
        wb_write(3'd7, 16'h0003);
        checks++; if (dut.sb_cnt[7] !== 2'd0) begin errors++; $display("FAIL dec_at_zero: got %0d want 0", dut.sb_cnt[7]); end
        in_valid = 1'b1; instruction = 16'h4801;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL jsr_after_underflow_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        wb_write(3'd7, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_operand_select();
        test_raw();
        test_backpressure();
        test_flush();
        test_saturation();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
